// File: rtl/aes_inv_cipher_ctrl_pkg.sv
// aes_inv_cipher_ctrl_pkg: shared states, round constants and key-index type for the AES-128 cipher controllers
package aes_inv_cipher_ctrl_pkg;
  localparam int NR = 10;
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] rk_idx_t;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, HOLD} state_t;
endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// aes_inv_cipher_ctrl_if: handshake, key-status and datapath-control bundle of the inverse cipher controller
interface aes_inv_cipher_ctrl_if;
  import aes_inv_cipher_ctrl_pkg::*;
  logic keyReady;
  logic keyChange;
  logic inValid;
  logic inReady;
  logic outValid;
  logic outReady;
  rk_idx_t rkSel;
  logic selFirst;
  logic selLast;
  logic stateEn;
  logic busy;
  logic abort;
  modport master (
    input keyReady, keyChange, inValid, outReady,
    output inReady, outValid, rkSel, selFirst, selLast, stateEn, busy, abort
  );
  modport slave (
    output keyReady, keyChange, inValid, outReady,
    input inReady, outValid, rkSel, selFirst, selLast, stateEn, busy, abort
  );
endinterface

// File: rtl/aes_inv_cipher_ctrl_round_cnt.sv
// aes_inv_cipher_ctrl_round_cnt: loadable round-key down-counter that saturates at zero
module aes_inv_cipher_ctrl_round_cnt
  import aes_inv_cipher_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    load,
  input  logic    dec,
  output rk_idx_t cnt
);
  logic zero;
  assign zero = cnt == '0;
  // clear wins over load, decrement stops at zero so the key index never wraps
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= rk_idx_t'(NR);
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: sequences one AES-128 decryption block through round keys rk10..rk0
module aes_inv_cipher_ctrl
  import aes_inv_cipher_ctrl_pkg::*;
(
  input logic clk,
  input logic reset,
  aes_inv_cipher_ctrl_if.master bus
);
  state_t state, state_nx;
  rk_idx_t cnt;
  logic hs, clr, dec, abort_q;
  assign bus.busy = state == LOAD || state == ROUND || state == FINAL;
  assign bus.inReady = bus.keyReady && !bus.keyChange && (state == IDLE || (state == HOLD && bus.outReady));
  assign bus.outValid = state == HOLD;
  assign bus.stateEn = bus.busy;
  assign bus.selFirst = state == LOAD;
  assign bus.selLast = state == FINAL;
  assign bus.rkSel = bus.busy ? cnt : '0;
  assign bus.abort = abort_q;
  assign hs = bus.inValid && bus.inReady;
  assign clr = bus.busy && bus.keyChange;
  assign dec = state == LOAD || state == ROUND;
  aes_inv_cipher_ctrl_round_cnt u_cnt (
    .clk(clk), .reset(reset), .clr(clr), .load(hs), .dec(dec), .cnt(cnt)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // abort is a registered one-cycle pulse marking the discarded block
  always_ff @(posedge clk or posedge reset)
    if (reset) abort_q <= 1'b0;
    else abort_q <= clr;
  // next-state: key change aborts, a handshake always starts a new block
  always_comb begin
    state_nx = state;
    state_nx = clr ? IDLE :
               hs ? LOAD :
               state == LOAD ? ROUND :
               (state == ROUND && cnt == rk_idx_t'(1)) ? FINAL :
               state == FINAL ? HOLD :
               (state == HOLD && bus.outReady) ? IDLE : state;
  end
endmodule
